// File: rtl/display_pkg.sv
// display_pkg: shared state encodings, frame constants and BCD helper for the result display
package display_pkg;
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_READY = 2'b01;
    localparam logic [1:0] ST_BUSY  = 2'b10;
    localparam logic [1:0] ST_RES   = 2'b11;
    localparam logic [5:0] HDR_PREFIX = 6'b101010;
    localparam int NDIG    = 10;
    localparam int FRAME_W = 8 + 8 * NDIG;
    typedef enum logic [2:0] {IDLE, CONV, HDR, PAY, DONE} fsm_t;
    // add 3 to every digit >= 5 ahead of the next double-dabble shift
    function automatic logic [4*NDIG-1:0] bcd_adj(input logic [4*NDIG-1:0] v);
        logic [4*NDIG-1:0] r;
        for (int i = 0; i < NDIG; i++)
            r[4*i +: 4] = (v[4*i +: 4] >= 4'd5) ? v[4*i +: 4] + 4'd3 : v[4*i +: 4];
        return r;
    endfunction
endpackage

// File: rtl/display_module_bin2bcd32.sv
// bin2bcd32: iterative shift-add-3 converter, done pulses 32 cycles after start
module bin2bcd32
    import display_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] bin,
    output logic        busy,
    output logic        done,
    output logic [39:0] bcd
);
    logic [31:0] sh;
    logic [4:0]  cnt;
    logic [39:0] adj;
    assign adj = bcd_adj(bcd);
    // first shift happens on the start edge itself (nothing to adjust from zero)
    always_ff @(posedge clk) begin
        if (rst) begin
            sh   <= '0;
            bcd  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else if (start) begin
            sh   <= {bin[30:0], 1'b0};
            bcd  <= {39'b0, bin[31]};
            cnt  <= 5'd1;
            busy <= 1'b1;
            done <= 1'b0;
        end else if (busy) begin
            bcd  <= {adj[38:0], sh[31]};
            sh   <= {sh[30:0], 1'b0};
            cnt  <= cnt + 5'd1;
            busy <= cnt != 5'd31;
            done <= cnt == 5'd31;
        end else begin
            done <= 1'b0;
        end
    end
endmodule

// File: rtl/display_module.sv
// display_module: frames a header (plus BCD results in state 11) on DS at every system state change
module display_module
    import display_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  state,
    input  logic [31:0] ret22,
    input  logic [31:0] ret33,
    output logic [1:0]  DS
);
    fsm_t                fsm, fsm_d;
    logic [1:0]          state_q, ds_d;
    logic [FRAME_W-1:0]  sr, sr_d;
    logic [6:0]          cnt, cnt_d;
    logic                res_q, res_d;
    logic                chg, start, sending, hdr_end, pay_end, conv_done;
    logic                busy22, busy33, done22, done33;
    logic [39:0]         bcd22, bcd33;

    assign chg       = state != state_q;
    assign start     = chg && state == ST_RES;
    assign sending   = fsm == HDR || fsm == PAY;
    assign hdr_end   = fsm == HDR && cnt == 7'd7;
    assign pay_end   = fsm == PAY && cnt == 7'd79;
    assign conv_done = fsm == CONV && done22 && done33 && !busy22 && !busy33;

    bin2bcd32 u_cv22 (.clk(clk), .rst(rst), .start(start), .bin(ret22), .busy(busy22), .done(done22), .bcd(bcd22));
    bin2bcd32 u_cv33 (.clk(clk), .rst(rst), .start(start), .bin(ret33), .busy(busy33), .done(done33), .bcd(bcd33));

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm     <= IDLE;
            state_q <= ST_IDLE;
            sr      <= '0;
            cnt     <= '0;
            res_q   <= 1'b0;
            DS      <= 2'b00;
        end else begin
            fsm     <= fsm_d;
            state_q <= state;
            sr      <= sr_d;
            cnt     <= cnt_d;
            res_q   <= res_d;
            DS      <= ds_d;
        end
    end

    // any change wins over whatever phase the current frame is in
    always_comb begin
        fsm_d = chg ? (state == ST_IDLE ? IDLE : state == ST_RES ? CONV : HDR)
              : conv_done ? HDR
              : hdr_end ? (res_q ? PAY : DONE)
              : pay_end ? DONE
              : fsm;
    end

    // the restart edge itself emits 00, so a restarted frame begins one cycle later
    always_comb begin
        sr_d  = chg ? {HDR_PREFIX, state, 80'b0}
              : conv_done ? {HDR_PREFIX, ST_RES, bcd22, bcd33}
              : sending ? {sr[FRAME_W-2:0], 1'b0}
              : sr;
        cnt_d = (chg || conv_done || hdr_end) ? 7'd0 : sending ? cnt + 7'd1 : cnt;
        res_d = chg ? state == ST_RES : res_q;
        ds_d  = (!chg && sending) ? {1'b1, sr[FRAME_W-1]} : 2'b00;
    end
endmodule

// File: tb/tb_display_module.sv
// tb_display_module: randomized and directed checks of DS against a frame-level reference model
module tb_display_module;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  state = 2'b00;
    logic [31:0] ret22 = '0;
    logic [31:0] ret33 = '0;
    logic [1:0]  DS;
    int          ncmp = 0;
    int          nerr = 0;
    logic [1:0]  prev = 2'b00;
    logic [1:0]  q[$];
    logic [1:0]  exp_ds;

    display_module dut (.clk(clk), .rst(rst), .state(state), .ret22(ret22), .ret33(ret33), .DS(DS));

    always #5 clk = ~clk;

    function automatic void push_hdr(input logic [1:0] s);
        logic [7:0] h;
        h = {6'b101010, s};
        for (int i = 7; i >= 0; i--) q.push_back({1'b1, h[i]});
    endfunction

    // decimal digits most significant first, each digit MSB first
    function automatic void push_val(input longint unsigned v);
        longint unsigned p;
        logic [3:0] dig;
        p = 64'd1000000000;
        for (int d = 0; d < 10; d++) begin
            dig = 4'((v / p) % 10);
            for (int b = 3; b >= 0; b--) q.push_back({1'b1, dig[b]});
            p = p / 10;
        end
    endfunction

    // expected DS after each edge: the change edge shows 00, then the queued frame, then 00
    task automatic step(input string tag);
        @(posedge clk);
        if (rst) begin
            q.delete();
            prev = 2'b00;
            exp_ds = 2'b00;
        end else if (state != prev) begin
            q.delete();
            prev = state;
            exp_ds = 2'b00;
            if (state == 2'b11) begin
                repeat (32) q.push_back(2'b00);
                push_hdr(state);
                push_val(longint'(ret22));
                push_val(longint'(ret33));
            end else if (state != 2'b00) begin
                push_hdr(state);
            end
        end else begin
            exp_ds = (q.size() > 0) ? q.pop_front() : 2'b00;
        end
        #1;
        ncmp++;
        assert (DS === exp_ds) else begin
            nerr++;
            $error("FAIL %s cmp %0d: DS=%b expected %b", tag, ncmp, DS, exp_ds);
        end
    endtask

    task automatic run(input int n, input string tag);
        repeat (n) step(tag);
    endtask

    initial begin
        rst = 1'b1; state = 2'b00;
        step("reset");
        rst = 1'b0;
        run(10, "idle");
        state = 2'b01;
        run(12, "hdr01");
        state = 2'b00;
        run(2, "to00");
        state = 2'b01;
        run(3, "hdr01_part");
        state = 2'b10;
        run(12, "hdr10");
        ret22 = 32'd124812789; ret33 = 32'd12828; state = 2'b11;
        run(5, "conv");
        ret22 = $urandom; ret33 = $urandom;
        run(120, "res_dir");
        state = 2'b00;
        run(2, "to00b");
        ret22 = 32'hFFFF_FFFF; ret33 = 32'd0; state = 2'b11;
        run(125, "res_max");
        state = 2'b00;
        run(2, "to00c");
        state = 2'b11;
        run(10, "conv_pre_abort");
        state = 2'b00;
        run(40, "conv_abort");
        ret22 = $urandom; ret33 = $urandom_range(0, 999); state = 2'b11;
        run(60, "pre_rst");
        rst = 1'b1;
        step("rst_mid");
        rst = 1'b0;
        run(125, "post_rst");
        for (int k = 0; k < 25; k++) begin
            state = 2'($urandom_range(0, 3));
            ret22 = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 999);
            ret33 = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 99999);
            run($urandom_range(1, 130), "rand");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
